nfc_tcnt_seq: RTL and testbench

//  Phase sequencer for the 3-bit NFC timing counter. Drives its t_en/tconf_c and watches its t_cnt.

---
 rtl/nfc_tcnt_seq.sv | 153 +++++++++++++++
 tb/tb_nfc_tcnt_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nfc_tcnt_seq.sv
// rtl/nfc_tcnt_seq.sv - phase sequencer for the 3-bit NFC timing counter
// Walks 1..4 programmed phases, each a terminal count repeated rep+1 times.
module nfc_tcnt_seq #(
    parameter int CW    = 3,
    parameter int REP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_nph,
    input  logic [4*CW-1:0]    cfg_tc,
    input  logic [4*REP_W-1:0] cfg_rep,
    input  logic [CW-1:0]      t_cnt,
    output logic               t_en,
    output logic [CW-1:0]      tconf_c,
    output logic               busy,
    output logic               done,
    output logic [1:0]         phase,
    output logic               tick,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [CW-1:0]      tconf_q, tconf_d;
    logic               err_q, err_d;
    logic [1:0]         nph_q, nph_d;
    logic [4*CW-1:0]    tc_q, tc_d;
    logic [4*REP_W-1:0] rep_q, rep_d;

    logic [REP_W-1:0]   rep_sel;
    logic [CW-1:0]      tc_nx;
    logic               wrap;

    // Repeat limit of the active phase and terminal count of the phase after it.
    always_comb begin
        rep_sel = rep_q[0 +: REP_W];
        tc_nx   = tc_q[CW +: CW];
        case (phase_q)
            2'd0: begin
                rep_sel = rep_q[0 +: REP_W];
                tc_nx   = tc_q[CW +: CW];
            end
            2'd1: begin
                rep_sel = rep_q[REP_W +: REP_W];
                tc_nx   = tc_q[2*CW +: CW];
            end
            2'd2: begin
                rep_sel = rep_q[2*REP_W +: REP_W];
                tc_nx   = tc_q[3*CW +: CW];
            end
            default: begin
                rep_sel = rep_q[3*REP_W +: REP_W];
                tc_nx   = tc_q[3*CW +: CW];
            end
        endcase
    end

    assign wrap = (state_q == S_RUN) && (t_cnt == tconf_q);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        rep_cnt_d = rep_cnt_q;
        tconf_d   = tconf_q;
        err_d     = err_q;
        nph_d     = nph_q;
        tc_d      = tc_q;
        rep_d     = rep_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_LOAD;
                        err_d     = 1'b0;
                        phase_d   = 2'd0;
                        rep_cnt_d = '0;
                        nph_d     = cfg_nph;
                        tc_d      = cfg_tc;
                        rep_d     = cfg_rep;
                        tconf_d   = cfg_tc[CW-1:0];
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    // An overrun value is flagged and never treated as a wrap.
                    if (t_cnt > tconf_q) begin
                        err_d = 1'b1;
                    end
                    if (wrap) begin
                        if (rep_cnt_q != rep_sel) begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end else if (phase_q == nph_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_GAP;
                            phase_d   = phase_q + 2'd1;
                            rep_cnt_d = '0;
                            tconf_d   = tc_nx;
                        end
                    end
                end
                S_GAP:   state_d = S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            rep_cnt_q <= '0;
            tconf_q   <= '0;
            err_q     <= 1'b0;
            nph_q     <= 2'd0;
            tc_q      <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rep_cnt_q <= rep_cnt_d;
            tconf_q   <= tconf_d;
            err_q     <= err_d;
            nph_q     <= nph_d;
            tc_q      <= tc_d;
            rep_q     <= rep_d;
        end
    end

    assign t_en    = (state_q == S_RUN);
    assign busy    = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_GAP);
    assign done    = (state_q == S_DONE);
    assign tick    = wrap;
    assign tconf_c = tconf_q;
    assign phase   = phase_q;
    assign err     = err_q;

endmodule

// File: tb/tb_nfc_tcnt_seq.sv
// tb/tb_nfc_tcnt_seq.sv - self-checking bench for nfc_tcnt_seq
// Expected traces are built per phase/repeat/count from the programmed config.
module tb_nfc_tcnt_seq;
    localparam int CW    = 3;
    localparam int REP_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [1:0]         cfg_nph = 2'd0;
    logic [4*CW-1:0]    cfg_tc = '0;
    logic [4*REP_W-1:0] cfg_rep = '0;
    logic [CW-1:0]      t_cnt;
    logic               t_en;
    logic [CW-1:0]      tconf_c;
    logic               busy;
    logic               done;
    logic [1:0]         phase;
    logic               tick;
    logic               err;

    logic [CW-1:0]      cnt_q;
    logic               force_en = 1'b0;
    logic [CW-1:0]      force_val = '0;

    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [9:0]         exp_q[$];
    logic               exp_err = 1'b0;
    logic [1:0]         last_ph = 2'd0;
    logic [CW-1:0]      last_tc = '0;

    nfc_tcnt_seq #(.CW(CW), .REP_W(REP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .cfg_nph (cfg_nph),
        .cfg_tc  (cfg_tc),
        .cfg_rep (cfg_rep),
        .t_cnt   (t_cnt),
        .t_en    (t_en),
        .tconf_c (tconf_c),
        .busy    (busy),
        .done    (done),
        .phase   (phase),
        .tick    (tick),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Timing counter: cleared while disabled, wraps at its terminal count.
    always @(posedge clk or posedge rst) begin
        if (rst)                  cnt_q <= '0;
        else if (!t_en)           cnt_q <= '0;
        else if (cnt_q == tconf_c) cnt_q <= '0;
        else                      cnt_q <= cnt_q + 3'd1;
    end
    assign t_cnt = force_en ? force_val : cnt_q;

    function automatic logic [9:0] obs();
        return {busy, t_en, done, tick, err, phase, tconf_c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record = {busy, t_en, done, tick, err, phase, tconf}
    task automatic build(input logic [1:0] nph, input logic [11:0] tc, input logic [15:0] rep);
        logic [2:0] t;
        logic [3:0] r;
        exp_q.delete();
        exp_q.push_back({5'b10000, 2'd0, tc[2:0]});
        for (int i = 0; i <= int'(nph); i++) begin
            t = tc[i*3 +: 3];
            r = rep[i*4 +: 4];
            for (int k = 0; k <= int'(r); k++)
                for (int c = 0; c <= int'(t); c++)
                    exp_q.push_back({3'b110, (c == int'(t)), 1'b0, 2'(i), t});
            if (i < int'(nph))
                exp_q.push_back({5'b10000, 2'(i + 1), tc[(i+1)*3 +: 3]});
        end
        exp_q.push_back({5'b00100, nph, tc[int'(nph)*3 +: 3]});
    endtask

    task automatic run_seq(input logic [1:0] nph, input logic [11:0] tc, input logic [15:0] rep,
                           input int abort_at, input int force_at, input bit rnd);
        logic [9:0] e;
        bit aborted;
        aborted = 1'b0;
        build(nph, tc, rep);
        @(negedge clk);
        cfg_nph = nph;
        cfg_tc  = tc;
        cfg_rep = rep;
        start   = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            e = exp_q[k];
            if (force_at >= 0 && k > force_at) e[5] = 1'b1;
            chk($sformatf("seq_k%0d", k), 32'(obs()), 32'(e));
            if (k == 0) begin
                cfg_nph = 2'($urandom);
                cfg_tc  = 12'($urandom);
                cfg_rep = 16'($urandom);
            end
            start = (rnd && k < exp_q.size() - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            force_en  = (k == force_at);
            force_val = 3'd5;
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                chk("abort_next", 32'(obs() >> 3), 32'({4'b0000, e[5], e[4:3]}));
                @(negedge clk);
                chk("abort_nodone", 32'(obs() >> 3), 32'({4'b0000, e[5], e[4:3]}));
                exp_err = e[5];
                last_ph = e[4:3];
                aborted = 1'b1;
                break;
            end
        end
        force_en = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            e = {4'b0000, (force_at >= 0), nph, tc[int'(nph)*3 +: 3]};
            chk("idle_after_done", 32'(obs()), 32'(e));
            exp_err = (force_at >= 0);
            last_ph = nph;
            last_tc = tc[int'(nph)*3 +: 3];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0]  nph;
        logic [11:0] tc;
        logic [15:0] rep;

        #2;
        chk("reset_outs", 32'(obs()), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(obs()), 32'(0));

        run_seq(2'd0, 12'h003, 16'h0000, -1, -1, 1'b0);
        run_seq(2'd1, 12'h002, 16'h0021, -1, -1, 1'b0);
        run_seq(2'd0, 12'h003, 16'h0000, 2, -1, 1'b0);
        run_seq(2'd0, 12'h003, 16'h0000, -1, -1, 1'b0);
        run_seq(2'd2, 12'h1CA, 16'h0312, -1, -1, 1'b1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(obs()), 32'({4'b0000, exp_err, last_ph, last_tc}));

        run_seq(2'd0, 12'h000, 16'h000F, -1, -1, 1'b0);
        run_seq(2'd0, 12'h003, 16'h0001, -1, 2, 1'b0);
        run_seq(2'd3, 12'hFA3, 16'h1203, -1, -1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            nph = 2'($urandom);
            tc  = 12'($urandom);
            rep = 16'($urandom);
            run_seq(nph, tc, rep, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1,
                    -1, 1'b1);
        end

        // Async reset in the middle of a run that has already flagged an overrun.
        @(negedge clk);
        cfg_nph = 2'd0;
        cfg_tc  = 12'h003;
        cfg_rep = 16'h0001;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        force_en  = 1'b1;
        force_val = 3'd5;
        @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_run", 32'({t_en, err}), 32'(2'b11));
        rst = 1'b1;
        #1;
        chk("async_rst", 32'(obs()), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_post_rst", 32'(obs()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
